// File: rtl/x_pkg.sv
// Shared definitions for the event-line conditioner and its downstream FSM bench.
package x_pkg;

  localparam int CH_U = 0;
  localparam int CH_O = 1;
  localparam int CH_D = 2;
  localparam int N_CH = 3;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // Fixed priority u > o > d; returns a one-hot grant (or zero when idle).
  function automatic logic [N_CH-1:0] prio_grant(input logic [N_CH-1:0] req);
    logic [N_CH-1:0] grant;
    grant = '0;
    if (req[CH_U])      grant[CH_U] = 1'b1;
    else if (req[CH_O]) grant[CH_O] = 1'b1;
    else if (req[CH_D]) grant[CH_D] = 1'b1;
    return grant;
  endfunction

endpackage

// File: rtl/x_debounce.sv
// One event line: two-flop synchroniser, hold-time debounce counter and accepted level.
// rise_o is combinational so the parent can latch the event on the same edge stable flips.
module x_debounce
  import x_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic res,
  input  logic b_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q + 1'b1;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= b_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = stable_d & ~stable_q;

endmodule

// File: rtl/x_input_cond.sv
// Conditions three bouncing event lines into mutually exclusive one-cycle pulses
// for the sequencer FSM: debounce per line, latch rising edges, then fixed-priority grant.
module x_input_cond
  import x_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            res,
  input  logic            bu,
  input  logic            bo,
  input  logic            bd,
  output logic            xu,
  output logic            xo,
  output logic            xd,
  output logic [N_CH-1:0] lvl,
  output logic [N_CH-1:0] pend
);

  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] x_q, x_d;

  assign raw[CH_U] = bu;
  assign raw[CH_O] = bo;
  assign raw[CH_D] = bd;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      x_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk      (clk),
        .res      (res),
        .b_i      (raw[gi]),
        .stable_o (stable[gi]),
        .rise_o   (rise[gi])
      );
    end
  endgenerate

  // A new rise on the channel being granted re-arms it, producing a second pulse.
  always_comb begin
    grant  = prio_grant(pend_q);
    x_d    = grant;
    pend_d = (pend_q & ~grant) | rise;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      pend_q <= '0;
      x_q    <= '0;
    end else begin
      pend_q <= pend_d;
      x_q    <= x_d;
    end
  end

  assign xu   = x_q[CH_U];
  assign xo   = x_q[CH_O];
  assign xd   = x_q[CH_D];
  assign lvl  = stable;
  assign pend = pend_q;

endmodule
